// File: rtl/pipelined_compadder.sv
// Compound adder/subtractor: s = a+B', t = a+B'+1, one W-bit segment resolved per stage by carry-select.
// Latency SEG cycles; all stages stall together when the output is held (in_ready = !out_valid | out_ready).
module pipelined_compadder #(
   parameter int N   = 16,
   parameter int SEG = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N:0]   s,
   output logic [N:0]   t
);
   localparam int W = N / SEG;

   generate
      if ((N % SEG) != 0) begin : g_bad_param
         $error("pipelined_compadder: N must be a multiple of SEG");
      end
   endgenerate

   logic [SEG-1:0][N-1:0] a_q, bp_q, s_q, t_q;
   logic [SEG-1:0]        cs_q, ct_q, vld_q;

   logic [SEG-1:0][N-1:0] a_src, bp_src, s_src, t_src, s_nxt, t_nxt;
   logic [SEG-1:0]        cs_src, ct_src, vld_src, cs_nxt, ct_nxt;
   logic [W:0]            sum_s, sum_t;
   logic                  adv;

   assign out_valid = vld_q[SEG-1];
   assign adv       = !out_valid | out_ready;
   assign in_ready  = adv;
   assign s         = {cs_q[SEG-1], s_q[SEG-1]};
   assign t         = {ct_q[SEG-1], t_q[SEG-1]};

   // Stage k's inputs: stage 1 takes the ports with fixed carries 0 (s chain) / 1 (t chain).
   always_comb begin
      a_src   = a_q;
      bp_src  = bp_q;
      s_src   = s_q;
      t_src   = t_q;
      cs_src  = cs_q;
      ct_src  = ct_q;
      vld_src = vld_q;
      a_src[0]   = a;
      bp_src[0]  = sub ? ~b : b;
      s_src[0]   = '0;
      t_src[0]   = '0;
      cs_src[0]  = 1'b0;
      ct_src[0]  = 1'b1;
      vld_src[0] = in_valid;
      for (int k = 1; k < SEG; k++) begin
         a_src[k]   = a_q[k-1];
         bp_src[k]  = bp_q[k-1];
         s_src[k]   = s_q[k-1];
         t_src[k]   = t_q[k-1];
         cs_src[k]  = cs_q[k-1];
         ct_src[k]  = ct_q[k-1];
         vld_src[k] = vld_q[k-1];
      end
   end

   // Both candidates of a segment are shared by the s and t chains; only the select differs.
   always_comb begin
      s_nxt  = s_src;
      t_nxt  = t_src;
      cs_nxt = '0;
      ct_nxt = '0;
      sum_s  = '0;
      sum_t  = '0;
      for (int k = 0; k < SEG; k++) begin
         sum_s = {1'b0, a_src[k][k*W +: W]} + {1'b0, bp_src[k][k*W +: W]};
         sum_t = sum_s + (W+1)'(1);
         s_nxt[k][k*W +: W] = cs_src[k] ? sum_t[W-1:0] : sum_s[W-1:0];
         t_nxt[k][k*W +: W] = ct_src[k] ? sum_t[W-1:0] : sum_s[W-1:0];
         cs_nxt[k] = cs_src[k] ? sum_t[W] : sum_s[W];
         ct_nxt[k] = ct_src[k] ? sum_t[W] : sum_s[W];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_q   <= '0;
         bp_q  <= '0;
         s_q   <= '0;
         t_q   <= '0;
         cs_q  <= '0;
         ct_q  <= '0;
         vld_q <= '0;
      end else if (adv) begin
         a_q   <= a_src;
         bp_q  <= bp_src;
         s_q   <= s_nxt;
         t_q   <= t_nxt;
         cs_q  <= cs_nxt;
         ct_q  <= ct_nxt;
         vld_q <= vld_src;
      end
   end

   // Operand bits already resolved, and the last stage's forwarded copy, have no reader.
   logic unused_fwd;
   assign unused_fwd = ^{a_src, bp_src, a_q[SEG-1], bp_q[SEG-1]};

endmodule

// File: tb/tb_pipelined_compadder.sv
// Directed-vector and stream bench for pipelined_compadder (N=8,SEG=4) plus a parameter sweep.
module tb_pipelined_compadder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       in_valid, in_ready, sub, out_valid, out_ready;
   logic [7:0] a, b;
   logic [8:0] s, t;

   pipelined_compadder #(.N(8), .SEG(4)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
      .s(s), .t(t)
   );

   // Shared stimulus for the sweep instances; each takes the low NN bits.
   logic [31:0] ra, rb;
   logic        rsub, riv, rrdy;

   for (genvar g = 0; g < 4; g++) begin : sw
      localparam int NN = (g == 0) ? 1 : ((g == 3) ? 32 : 8);
      localparam int SS = (g <= 1) ? 1 : ((g == 2) ? 8 : 4);
      logic          ir, ov;
      logic [NN-1:0] a, b;
      logic [NN:0]   s, t, e_s, e_t, bp;
      logic [127:0]  exp, got;
      logic [127:0]  q[$];
      assign a   = ra[NN-1:0];
      assign b   = rb[NN-1:0];
      assign bp  = {1'b0, rsub ? ~b : b};
      assign e_s = {1'b0, a} + bp;
      assign e_t = e_s + (NN+1)'(1);
      assign exp = {64'(e_s), 64'(e_t)};
      assign got = {64'(s), 64'(t)};
      pipelined_compadder #(.N(NN), .SEG(SS)) dut (
         .clk(clk), .reset(reset), .in_valid(riv), .in_ready(ir),
         .a(a), .b(b), .sub(rsub), .out_valid(ov), .out_ready(rrdy),
         .s(s), .t(t)
      );
   end

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
      end
   endtask

   function automatic logic [17:0] model(input logic [7:0] x, input logic [7:0] y, input logic m);
      logic [8:0] yp, es, et;
      yp = {1'b0, m ? ~y : y};
      es = {1'b0, x} + yp;
      et = es + 9'd1;
      return {es, et};
   endfunction

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       sub;
      logic [8:0] es;
      logic [8:0] et;
   } vec_t;

   vec_t vecs[12];

   task automatic run_vec(input vec_t v, input string nm);
      int lat;
      @(negedge clk);
      a = v.a; b = v.b; sub = v.sub; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; a = 8'h00; b = 8'h00; sub = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk({nm, " latency"}, 64'(lat), 64'd4);
      chk({nm, " s"}, 64'(s), 64'(v.es));
      chk({nm, " t"}, 64'(t), 64'(v.et));
      @(negedge clk);
      chk({nm, " out_valid drops"}, 64'(out_valid), 64'd0);
   endtask

   task automatic stream(input int nops, input bit bp, input string nm);
      int          issued, cyc;
      logic [17:0] q[$];
      logic [17:0] ent;
      logic [8:0]  hs, ht;
      bit          hold;
      issued = 0; cyc = 0; hs = '0; ht = '0;
      while ((issued < nops || q.size() != 0) && cyc < 300) begin
         @(negedge clk);
         hold = bp && cyc >= 6 && cyc < 11;
         if (issued < nops) begin
            in_valid = 1'b1;
            a   = 8'($urandom_range(0, 255));
            b   = 8'($urandom_range(0, 255));
            sub = 1'($urandom_range(0, 1));
         end else begin
            in_valid = 1'b0;
         end
         out_ready = !hold;
         #1;
         if (hold) begin
            chk({nm, " in_ready held"}, 64'(in_ready), 64'd0);
            if (cyc == 6) begin
               chk({nm, " out_valid full"}, 64'(out_valid), 64'd1);
               hs = s; ht = t;
            end else begin
               chk({nm, " s stable"}, 64'(s), 64'(hs));
               chk({nm, " t stable"}, 64'(t), 64'(ht));
            end
         end else if (in_valid) begin
            chk({nm, " in_ready"}, 64'(in_ready), 64'd1);
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               n_cmp++; n_fail++;
               $display("FAIL %s spurious output: got s=0x%0h t=0x%0h, expected none", nm, s, t);
            end else begin
               ent = q.pop_front();
               chk({nm, " {s,t}"}, 64'({s, t}), 64'(ent));
            end
         end
         if (in_valid && in_ready) begin
            q.push_back(model(a, b, sub));
            issued++;
         end
         cyc++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      chk({nm, " all results out"}, 64'(q.size() + (nops - issued)), 64'd0);
      if (!bp) chk({nm, " one per cycle"}, 64'(cyc), 64'(nops + 4));
   endtask

`define SW_STEP(g) \
      if (ph == 0 && sw[g].ov && slat[g] == 0) slat[g] = c; \
      if (sw[g].ov && rrdy) begin \
         if (sw[g].q.size() == 0) begin \
            n_cmp++; n_fail++; \
            $display("FAIL sweep%0d spurious output: got 0x%0h, expected none", g, sw[g].got); \
         end else begin \
            ent = sw[g].q.pop_front(); \
            chk($sformatf("sweep%0d s", g), sw[g].got[127:64], ent[127:64]); \
            chk($sformatf("sweep%0d t", g), sw[g].got[63:0], ent[63:0]); \
         end \
      end \
      if (riv && sw[g].ir) sw[g].q.push_back(sw[g].exp);

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int          slat[4];
      int          ph;
      logic [127:0] ent;

      vecs[0]  = '{8'hFF, 8'h01, 1'b0, 9'h100, 9'h101};
      vecs[1]  = '{8'd5,  8'd3,  1'b1, 9'h101, 9'h102};
      vecs[2]  = '{8'd3,  8'd5,  1'b1, 9'h0FD, 9'h0FE};
      vecs[3]  = '{8'h00, 8'h00, 1'b0, 9'h000, 9'h001};
      vecs[4]  = '{8'hFF, 8'hFF, 1'b0, 9'h1FE, 9'h1FF};
      vecs[5]  = '{8'h80, 8'h80, 1'b0, 9'h100, 9'h101};
      vecs[6]  = '{8'h00, 8'h00, 1'b1, 9'h0FF, 9'h100};
      vecs[7]  = '{8'hFF, 8'h00, 1'b1, 9'h1FE, 9'h1FF};
      vecs[8]  = '{8'h0F, 8'h01, 1'b0, 9'h010, 9'h011};
      vecs[9]  = '{8'h55, 8'hAA, 1'b0, 9'h0FF, 9'h100};
      vecs[10] = '{8'h80, 8'h01, 1'b1, 9'h17E, 9'h17F};
      vecs[11] = '{8'h12, 8'h34, 1'b0, 9'h046, 9'h047};

      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sub = 1'b0;
      ra = '0; rb = '0; rsub = 1'b0; riv = 1'b0; rrdy = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset out_valid", 64'(out_valid), 64'd0);
      chk("reset s", 64'(s), 64'd0);
      chk("reset t", 64'(t), 64'd0);
      chk("reset in_ready", 64'(in_ready), 64'd1);
      reset = 1'b0;

      for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      stream(20, 1'b0, "stream");
      stream(20, 1'b1, "backpressure");

      // Mid-flight reset: three accepted ops must vanish.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid = 1'b1; a = 8'(i + 1); b = 8'h10; sub = 1'b0; out_ready = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0; reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("midreset out_valid", 64'(out_valid), 64'd0);
      chk("midreset s", 64'(s), 64'd0);
      chk("midreset t", 64'(t), 64'd0);
      chk("midreset in_ready", 64'(in_ready), 64'd1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("midreset no ghost", 64'(out_valid), 64'd0);
      end
      run_vec(vecs[1], "after reset");

      // Parameter sweep: single-op latency, then random stream with random backpressure.
      for (int g = 0; g < 4; g++) slat[g] = 0;
      for (int c = 0; c < 2532; c++) begin
         @(negedge clk);
         ph = (c < 12) ? 0 : ((c < 2512) ? 1 : 2);
         ra = $urandom; rb = $urandom; rsub = 1'($urandom_range(0, 1));
         if (ph == 0) begin
            riv = (c == 0); rrdy = 1'b1;
         end else if (ph == 1) begin
            riv = ($urandom_range(0, 3) != 0); rrdy = ($urandom_range(0, 3) != 0);
         end else begin
            riv = 1'b0; rrdy = 1'b1;
         end
         #1;
         `SW_STEP(0)
         `SW_STEP(1)
         `SW_STEP(2)
         `SW_STEP(3)
      end
      chk("sweep0 latency", 64'(slat[0]), 64'd1);
      chk("sweep1 latency", 64'(slat[1]), 64'd1);
      chk("sweep2 latency", 64'(slat[2]), 64'd8);
      chk("sweep3 latency", 64'(slat[3]), 64'd4);
      chk("sweep0 drained", 64'(sw[0].q.size()), 64'd0);
      chk("sweep1 drained", 64'(sw[1].q.size()), 64'd0);
      chk("sweep2 drained", 64'(sw[2].q.size()), 64'd0);
      chk("sweep3 drained", 64'(sw[3].q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
      $finish;
   end

endmodule
